bus_turnaround_arbiter: RTL and testbench
=========================================

BUS_TURNAROUND_ARBITER -- requirements
Module: bus_turnaround_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is single, and the reset is asynchronous and active-high.
REQ-002 Parameter TURNAROUND_CYCLES, default 1, SHALL set the idle gap between bus directions; legal range 1..4.
REQ-003 Parameter MAX_BURST, default 6, SHALL set the maximum beats per grant when the other requester is waiting; legal range 1..15.
REQ-004 Parameter RD_PRIORITY, default 1, SHALL set the tie-break: 1 = read wins simultaneous requests, 0 = write wins.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- arst_in, in, 1: asynchronous active-high reset.
- rd_req, in, 1: controller requests inbound beats.
- rd_ready_in, in, 1: controller can accept a beat this cycle.
- bus_valid, in, 1: external source presents an inbound beat.
- bus_ready, out, 1: inbound beat accepted.
- rd_grant, out, 1: read owns the bus.
- rd_beat, out, 1: inbound transfer pulse.
- wr_req, in, 1: controller requests outbound beats.
- wr_valid_in, in, 1: controller presents an outbound beat.
- output_valid, out, 1: outbound beat valid on the bus.
- wr_grant, out, 1: write owns the bus.
- wr_beat, out, 1: outbound transfer pulse.
- driving_busses, out, 1: block drives the shared bus.

Function
REQ-006 The state machine SHALL have the states IDLE, RD, TURN and WR, held in a registered state; a 1-bit registered dir (0 = read, 1 = write) SHALL record the last owned direction.
REQ-007 Outputs SHALL be decoded as follows:
- rd_grant = (state==RD).
- bus_ready = rd_grant & rd_ready_in.
- rd_beat = bus_valid & bus_ready.
- wr_grant = (state==WR).
- output_valid = wr_grant & wr_valid_in.
- wr_beat = output_valid.
- driving_busses = wr_grant.
REQ-008 In IDLE, the winner SHALL be chosen as follows:
- The winner is the single requester, or the RD_PRIORITY choice when both request.
- If the winner's direction equals dir, next state = winner's state (grant 1 cycle after request sampled).
- Otherwise next state = TURN, with target = winner.
REQ-009 In RD, exit conditions SHALL be:
- rd_req low and wr_req high: go to TURN (target WR).
- rd_req low and wr_req low: go to IDLE.
- burst counter reaches MAX_BURST on an rd_beat while wr_req is high: go to TURN (target WR).
- Otherwise stay in RD.
REQ-010 WR SHALL mirror REQ-009, with roles and beats swapped.
REQ-011 A 4-bit burst counter SHALL:
- clear on entering RD or WR;
- increment on each beat;
- reset to 0 on reaching MAX_BURST when the other requester is idle, so the grant continues.
REQ-012 TURN SHALL last exactly TURNAROUND_CYCLES cycles, with no grant and driving_busses=0; on its last cycle dir is set to target.
REQ-013 On leaving TURN, next state SHALL be target if target's request is high, else IDLE.
REQ-014 A beat presented in the same cycle a state exits SHALL still complete, because outputs are decoded from the current state.
REQ-015 bus_ready and output_valid SHALL never be high in the same cycle.
REQ-016 A requester SHALL obtain the bus within MAX_BURST beats + TURNAROUND_CYCLES + 1 cycles of asserting request, provided the owner keeps transferring.

Reset
REQ-017 While arst_in is high, the block SHALL hold:
- state = IDLE, dir = 0, burst counter = 0, TURN counter = 0, target = RD;
- all outputs = 0.
REQ-018 Reset asserted mid-burst or mid-TURN SHALL force all outputs to 0 immediately, asynchronously, and drop any beat in progress.
REQ-019 After reset release, the first grant SHALL follow REQ-008 with dir = 0.

Configuration
REQ-020 Macro ARB_STATS_EN, when defined, SHALL add three outputs, each 16 bits, all 0 on reset:
- rd_beat_count: saturating count of rd_beat.
- wr_beat_count: saturating count of wr_beat.
- turn_count: saturating count of entries into TURN.
REQ-021 Without ARB_STATS_EN, those three ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 Reset, then rd_req=1 with bus_valid=rd_ready_in=1 -> rd_grant=1 from cycle 1, with one rd_beat per cycle.
REQ-023 Default parameters, RD active with wr_req=1 throughout -> exactly 6 rd_beat, then 1 TURN cycle with no grant, then wr_grant=1 and driving_busses=1.
REQ-024 rd_req and wr_req rise together from IDLE after reset with RD_PRIORITY=1 -> RD is granted immediately; with RD_PRIORITY=0 -> WR is granted after 1 TURN cycle.
REQ-025 TURNAROUND_CYCLES=3, wr_req drops during TURN (target WR) -> exactly 3 TURN cycles, then IDLE with dir=1; a later wr_req is granted with no TURN.
REQ-026 arst_in pulsed on the 3rd WR beat -> output_valid and driving_busses fall to 0 in the same cycle, state = IDLE, and the stats counters read 0 when ARB_STATS_EN is defined.
REQ-027 With ARB_STATS_EN defined, 70000 continuous rd_beat -> rd_beat_count saturates at 65535.

Source files
------------

// File: rtl/bus_turnaround_arbiter_if.sv
// Handshake bundle between the read/write controller and the turnaround arbiter.
// The slave modport is the arbiter's view; master is the controller's view.
interface bus_turnaround_arbiter_if;
    logic rd_req;
    logic rd_ready_in;
    logic bus_valid;
    logic bus_ready;
    logic rd_grant;
    logic rd_beat;
    logic wr_req;
    logic wr_valid_in;
    logic output_valid;
    logic wr_grant;
    logic wr_beat;
    logic driving_busses;

    modport slave (
        input  rd_req,
        input  rd_ready_in,
        input  bus_valid,
        input  wr_req,
        input  wr_valid_in,
        output bus_ready,
        output rd_grant,
        output rd_beat,
        output output_valid,
        output wr_grant,
        output wr_beat,
        output driving_busses
    );

    modport master (
        output rd_req,
        output rd_ready_in,
        output bus_valid,
        output wr_req,
        output wr_valid_in,
        input  bus_ready,
        input  rd_grant,
        input  rd_beat,
        input  output_valid,
        input  wr_grant,
        input  wr_beat,
        input  driving_busses
    );
endinterface

// File: rtl/bus_turnaround_arbiter.sv
// Read/write arbiter for a shared half-duplex bus with bounded bursts and an idle turnaround gap.
// Define ARB_STATS_EN to add saturating rd/wr beat and turnaround-entry counters.
module bus_turnaround_arbiter #(
    parameter int unsigned TURNAROUND_CYCLES = 1,
    parameter int unsigned MAX_BURST         = 6,
    parameter int unsigned RD_PRIORITY       = 1
) (
    input  logic                    clk,
    input  logic                    arst_in,
    bus_turnaround_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]             rd_beat_count,
    output logic [15:0]             wr_beat_count,
    output logic [15:0]             turn_count
`endif
);

    typedef enum logic [1:0] {StIdle, StRd, StTurn, StWr} state_e;

    localparam logic [1:0] TurnLast = 2'(TURNAROUND_CYCLES - 1);
    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    state_e     r_state, w_state_next;
    logic       r_dir, w_dir_next;
    logic       r_target, w_target_next;
    logic [3:0] r_burst, w_burst_next;
    logic [1:0] r_turn, w_turn_next;

    logic       w_rd_grant, w_wr_grant, w_rd_beat, w_wr_beat;
    logic       w_winner;
    logic [3:0] w_burst_inc;
    logic       w_burst_hit;

    // Outputs decode from the current state, so a beat in an exit cycle still completes.
    assign w_rd_grant         = (r_state == StRd);
    assign w_wr_grant         = (r_state == StWr);
    assign bus.rd_grant       = w_rd_grant;
    assign bus.wr_grant       = w_wr_grant;
    assign bus.bus_ready      = w_rd_grant & bus.rd_ready_in;
    assign w_rd_beat          = bus.bus_valid & w_rd_grant & bus.rd_ready_in;
    assign bus.rd_beat        = w_rd_beat;
    assign w_wr_beat          = w_wr_grant & bus.wr_valid_in;
    assign bus.output_valid   = w_wr_beat;
    assign bus.wr_beat        = w_wr_beat;
    assign bus.driving_busses = w_wr_grant;

    assign w_winner    = (bus.rd_req && bus.wr_req) ? (RD_PRIORITY == 0) : bus.wr_req;
    assign w_burst_inc = r_burst + 4'd1;
    assign w_burst_hit = (w_burst_inc == BurstMax);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_state  <= StIdle;
            r_dir    <= 1'b0;
            r_target <= 1'b0;
            r_burst  <= 4'd0;
            r_turn   <= 2'd0;
        end else begin
            r_state  <= w_state_next;
            r_dir    <= w_dir_next;
            r_target <= w_target_next;
            r_burst  <= w_burst_next;
            r_turn   <= w_turn_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_dir_next    = r_dir;
        w_target_next = r_target;
        w_burst_next  = r_burst;
        w_turn_next   = r_turn;
        unique case (r_state)
            StIdle: begin
                if (bus.rd_req || bus.wr_req) begin
                    if (w_winner == r_dir) begin
                        w_state_next = w_winner ? StWr : StRd;
                    end else begin
                        w_state_next  = StTurn;
                        w_target_next = w_winner;
                    end
                end
            end
            StRd: begin
                // Wrap at MAX_BURST so an uncontested grant keeps streaming.
                if (w_rd_beat) w_burst_next = w_burst_hit ? 4'd0 : w_burst_inc;
                if (!bus.rd_req) begin
                    w_state_next  = bus.wr_req ? StTurn : StIdle;
                    w_target_next = bus.wr_req ? 1'b1 : r_target;
                end else if (w_rd_beat && w_burst_hit && bus.wr_req) begin
                    w_state_next  = StTurn;
                    w_target_next = 1'b1;
                end
            end
            StWr: begin
                if (w_wr_beat) w_burst_next = w_burst_hit ? 4'd0 : w_burst_inc;
                if (!bus.wr_req) begin
                    w_state_next  = bus.rd_req ? StTurn : StIdle;
                    w_target_next = bus.rd_req ? 1'b0 : r_target;
                end else if (w_wr_beat && w_burst_hit && bus.rd_req) begin
                    w_state_next  = StTurn;
                    w_target_next = 1'b0;
                end
            end
            StTurn: begin
                if (r_turn == TurnLast) begin
                    w_dir_next = r_target;
                    if (r_target) w_state_next = bus.wr_req ? StWr : StIdle;
                    else          w_state_next = bus.rd_req ? StRd : StIdle;
                end else begin
                    w_turn_next = r_turn + 2'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (w_state_next != r_state) begin
            if (w_state_next == StTurn) w_turn_next = 2'd0;
            if (w_state_next == StRd || w_state_next == StWr) w_burst_next = 4'd0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt, r_turn_cnt;
    logic        w_turn_entry;

    assign w_turn_entry = (w_state_next == StTurn) && (r_state != StTurn);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_rd_cnt   <= 16'd0;
            r_wr_cnt   <= 16'd0;
            r_turn_cnt <= 16'd0;
        end else begin
            if (w_rd_beat && r_rd_cnt != 16'hFFFF)        r_rd_cnt   <= r_rd_cnt + 16'd1;
            if (w_wr_beat && r_wr_cnt != 16'hFFFF)        r_wr_cnt   <= r_wr_cnt + 16'd1;
            if (w_turn_entry && r_turn_cnt != 16'hFFFF)   r_turn_cnt <= r_turn_cnt + 16'd1;
        end
    end

    assign rd_beat_count = r_rd_cnt;
    assign wr_beat_count = r_wr_cnt;
    assign turn_count    = r_turn_cnt;
`endif

endmodule

// File: tb/tb_bus_turnaround_arbiter.sv
// Directed bench for bus_turnaround_arbiter: a vector table on the default instance plus
// hand sequences for burst limits, priority, long turnaround and asynchronous reset.
module tb_bus_turnaround_arbiter;

    logic clk = 1'b0;
    logic arst_in = 1'b1;
    logic rd_req = 1'b0, rd_ready_in = 1'b0, bus_valid = 1'b0, wr_req = 1'b0, wr_valid_in = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_turnaround_arbiter_if if0 ();
    bus_turnaround_arbiter_if if1 ();
    bus_turnaround_arbiter_if if2 ();

    assign if0.rd_req = rd_req;  assign if0.rd_ready_in = rd_ready_in;  assign if0.bus_valid = bus_valid;
    assign if0.wr_req = wr_req;  assign if0.wr_valid_in = wr_valid_in;
    assign if1.rd_req = rd_req;  assign if1.rd_ready_in = rd_ready_in;  assign if1.bus_valid = bus_valid;
    assign if1.wr_req = wr_req;  assign if1.wr_valid_in = wr_valid_in;
    assign if2.rd_req = rd_req;  assign if2.rd_ready_in = rd_ready_in;  assign if2.bus_valid = bus_valid;
    assign if2.wr_req = wr_req;  assign if2.wr_valid_in = wr_valid_in;

`ifdef ARB_STATS_EN
    logic [15:0] rd_cnt0, wr_cnt0, turn_cnt0, rd_cnt1, wr_cnt1, turn_cnt1, rd_cnt2, wr_cnt2, turn_cnt2;
    bus_turnaround_arbiter dut0 (.clk(clk), .arst_in(arst_in), .bus(if0),
        .rd_beat_count(rd_cnt0), .wr_beat_count(wr_cnt0), .turn_count(turn_cnt0));
    bus_turnaround_arbiter #(.RD_PRIORITY(0)) dut1 (.clk(clk), .arst_in(arst_in), .bus(if1),
        .rd_beat_count(rd_cnt1), .wr_beat_count(wr_cnt1), .turn_count(turn_cnt1));
    bus_turnaround_arbiter #(.TURNAROUND_CYCLES(3)) dut2 (.clk(clk), .arst_in(arst_in), .bus(if2),
        .rd_beat_count(rd_cnt2), .wr_beat_count(wr_cnt2), .turn_count(turn_cnt2));
`else
    bus_turnaround_arbiter dut0 (.clk(clk), .arst_in(arst_in), .bus(if0));
    bus_turnaround_arbiter #(.RD_PRIORITY(0)) dut1 (.clk(clk), .arst_in(arst_in), .bus(if1));
    bus_turnaround_arbiter #(.TURNAROUND_CYCLES(3)) dut2 (.clk(clk), .arst_in(arst_in), .bus(if2));
`endif

    // {rd_grant, bus_ready, rd_beat, wr_grant, output_valid, driving_busses}
    logic [5:0] o0, o1, o2;
    assign o0 = {if0.rd_grant, if0.bus_ready, if0.rd_beat, if0.wr_grant, if0.output_valid,
                 if0.driving_busses};
    assign o1 = {if1.rd_grant, if1.bus_ready, if1.rd_beat, if1.wr_grant, if1.output_valid,
                 if1.driving_busses};
    assign o2 = {if2.rd_grant, if2.bus_ready, if2.rd_beat, if2.wr_grant, if2.output_valid,
                 if2.driving_busses};

    // in = {rd_req, rd_ready_in, bus_valid, wr_req, wr_valid_in}
    typedef struct packed {
        logic [4:0] in;
        logic [5:0] exp;
    } vec_t;
    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        check("rd_wr_exclusive", {31'd0, (if0.bus_ready & if0.output_valid) |
              (if1.bus_ready & if1.output_valid) | (if2.bus_ready & if2.output_valid)}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] v);
        {rd_req, rd_ready_in, bus_valid, wr_req, wr_valid_in} = v;
    endtask

    task automatic do_reset();
        arst_in = 1'b1;
        set_in(5'b00000);
        repeat (2) @(posedge clk);
        #1;
        arst_in = 1'b0;
    endtask

    logic [5:0] s0 [16];
    logic [5:0] s1 [16];
    logic [5:0] s2 [16];
    int beats;
    logic any_grant;

    initial begin
        vecs[0]  = '{in: 5'b11100, exp: 6'b000000};
        vecs[1]  = '{in: 5'b11100, exp: 6'b111000};
        vecs[2]  = '{in: 5'b11100, exp: 6'b111000};
        vecs[3]  = '{in: 5'b10100, exp: 6'b100000};
        vecs[4]  = '{in: 5'b11000, exp: 6'b110000};
        vecs[5]  = '{in: 5'b11111, exp: 6'b111000};
        vecs[6]  = '{in: 5'b11111, exp: 6'b111000};
        vecs[7]  = '{in: 5'b11111, exp: 6'b111000};
        vecs[8]  = '{in: 5'b11111, exp: 6'b111000};
        vecs[9]  = '{in: 5'b11111, exp: 6'b000000};
        vecs[10] = '{in: 5'b11111, exp: 6'b000111};
        vecs[11] = '{in: 5'b11101, exp: 6'b000111};
        vecs[12] = '{in: 5'b11100, exp: 6'b000000};
        vecs[13] = '{in: 5'b11100, exp: 6'b111000};
        vecs[14] = '{in: 5'b01100, exp: 6'b111000};
        vecs[15] = '{in: 5'b01100, exp: 6'b000000};
        vecs[16] = '{in: 5'b00011, exp: 6'b000000};
        vecs[17] = '{in: 5'b00011, exp: 6'b000000};
        vecs[18] = '{in: 5'b00011, exp: 6'b000111};
        vecs[19] = '{in: 5'b00010, exp: 6'b000101};

        // Reset state, held while arst_in is high.
        set_in(5'b11111);
        #2;
        check("reset_outputs", {26'd0, o0}, 32'd0);
        do_reset();

        // Table: read stream, burst limit, turnaround, write, return and idle.
        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].in);
            #2;
            check($sformatf("vec%0d", i), {26'd0, o0}, {26'd0, vecs[i].exp});
            tick();
        end

        // Both request together from reset: burst limit, priority and turnaround length.
        do_reset();
        set_in(5'b11111);
        for (int c = 0; c < 16; c++) begin
            #2;
            s0[c] = o0; s1[c] = o1; s2[c] = o2;
            tick();
        end
        beats = 0;
        for (int c = 0; c < 8; c++) beats += int'(s0[c][3]);
        check("d0_rd_beats_before_turn", beats, 6);
        check("d0_rd_granted_cycle1", {31'd0, s0[1][5]}, 32'd1);
        check("d0_turn_no_grant", {30'd0, s0[7][5], s0[7][2]}, 32'd0);
        check("d0_wr_grant_drive", {30'd0, s0[8][2], s0[8][0]}, 32'd3);
        check("d1_wr_prio_turn", {30'd0, s1[1][5], s1[1][2]}, 32'd0);
        check("d1_wr_prio_grant", {31'd0, s1[2][2]}, 32'd1);
        check("d2_rd_last_beat", {31'd0, s2[6][3]}, 32'd1);
        any_grant = s2[7][5] | s2[7][2] | s2[8][5] | s2[8][2] | s2[9][5] | s2[9][2] | s2[9][0];
        check("d2_turn3_no_grant", {31'd0, any_grant}, 32'd0);
        check("d2_wr_after_turn3", {30'd0, s2[10][2], s2[10][0]}, 32'd3);

        // Write request dropped mid-turn on the long-turnaround instance.
        do_reset();
        set_in(5'b00011);
        any_grant = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) set_in(5'b00001);
            #2;
            any_grant |= (o2[5] | o2[2]);
            tick();
        end
        #2;
        check("d2_drop_no_grant", {31'd0, any_grant | o2[5] | o2[2]}, 32'd0);
        check("d2_dir_after_turn", {31'd0, dut2.r_dir}, 32'd1);
        set_in(5'b00011);
        tick();
        #2;
        check("d2_wr_no_turn", {31'd0, o2[2]}, 32'd1);
        tick();

        // Uncontested read keeps streaming past MAX_BURST; contention then trims the burst.
        do_reset();
        set_in(5'b11100);
        beats = 0;
        for (int c = 0; c < 11; c++) begin
            #2;
            beats += int'(o0[3]);
            tick();
        end
        check("d0_uncontested_beats", beats, 10);
        set_in(5'b11111);
        beats = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (!o0[5]) break;
            beats += int'(o0[3]);
            tick();
        end
        check("d0_beats_after_wrap", beats, 2);
        tick();
        #2;
        check("d0_wr_after_wrap", {31'd0, o0[2]}, 32'd1);
        tick();

        // Asynchronous reset on the third write beat.
        do_reset();
        set_in(5'b00011);
        for (int c = 0; c < 4; c++) tick();
        #2;
        check("d0_third_wr_beat", {30'd0, o0[1], o0[0]}, 32'd3);
`ifdef ARB_STATS_EN
        check("d0_wr_count_pre", {16'd0, wr_cnt0}, 32'd2);
        check("d0_turn_count_pre", {16'd0, turn_cnt0}, 32'd1);
`endif
        arst_in = 1'b1;
        #1;
        check("d0_async_reset_out", {26'd0, o0}, 32'd0);
`ifdef ARB_STATS_EN
        check("d0_stats_reset", {wr_cnt0, turn_cnt0 | rd_cnt0}, 32'd0);
`endif
        #1;
        arst_in = 1'b0;
        tick();
        #2;
        check("d0_post_reset_turn", {26'd0, o0}, 32'd0);
        tick();
        #2;
        check("d0_post_reset_wr", {30'd0, o0[2], o0[0]}, 32'd3);
        tick();

`ifdef ARB_STATS_EN
        do_reset();
        set_in(5'b11100);
        repeat (70002) @(posedge clk);
        #2;
        check("d0_rd_count_sat", {16'd0, rd_cnt0}, 32'd65535);
        check("d0_turn_count_zero", {16'd0, turn_cnt0}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
